// File: rtl/ex_mem_pkg.sv
// Shared types for the execute-to-memory stage: branch op encoding,
// buffer FSM states, the buffered entry layout and the branch resolver.
package ex_mem_pkg;

    localparam int EM_WIDTH  = 16;
    localparam int EM_REG_AW = 3;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_EQ   = 2'b01,
        BR_LT   = 2'b10,
        BR_GT   = 2'b11
    } br_op_t;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_t;

    typedef struct packed {
        logic [EM_WIDTH-1:0]  result;
        logic                 cout;
        logic [EM_REG_AW-1:0] dest;
        logic                 wr_en;
    } entry_t;

    // Branch outcome from the ALU comparison flags.
    function automatic logic br_resolve(input br_op_t op, input logic eq,
                                        input logic lt, input logic gt);
        logic taken;
        taken = 1'b0;
        case (op)
            BR_EQ:   taken = eq;
            BR_LT:   taken = lt;
            BR_GT:   taken = gt;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ex_mem_skid.sv
// Two-entry in-order buffer. Head register drives the outputs directly;
// the tail only holds a beat that arrived while the head was stalled.
module ex_mem_skid
    import ex_mem_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_flush,
    input  logic   i_push,
    input  logic   i_pop,
    input  entry_t i_entry,
    output logic   o_in_ready,
    output logic   o_out_valid,
    output entry_t o_head
);

    state_t r_state;
    entry_t r_head;
    entry_t r_tail;
    logic   r_in_ready;
    logic   r_out_valid;

    // Buffer FSM; ready/valid are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_head      <= '0;
            r_tail      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (i_flush) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (i_push) begin
                        r_head      <= i_entry;
                        r_state     <= ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (i_push && i_pop) begin
                        r_head <= i_entry;
                    end else if (i_push) begin
                        r_tail     <= i_entry;
                        r_state    <= FULL;
                        r_in_ready <= 1'b0;
                    end else if (i_pop) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (i_pop) begin
                        r_head     <= r_tail;
                        r_state    <= ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_head      = r_head;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: captures the ALU beat, resolves branches,
// raises a sticky overflow trap and buffers results behind valid/ready.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int WIDTH  = EM_WIDTH,
    parameter int REG_AW = EM_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_cout,
    input  logic              alu_lt,
    input  logic              alu_eq,
    input  logic              alu_gt,
    input  logic              alu_v,
    input  logic [REG_AW-1:0] in_dest,
    input  logic              in_wr_en,
    input  logic [1:0]        in_br_op,
    input  logic              in_trap_en,
    input  logic              flush,
    input  logic              trap_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic              out_cout,
    output logic [REG_AW-1:0] out_dest,
    output logic              out_wr_en,
    output logic              br_taken,
    output logic              ovf_trap,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_dest,
    output logic [WIDTH-1:0]  fwd_data
);

    logic   w_push;
    logic   w_pop;
    logic   w_taken;
    logic   w_trap_evt;
    logic   w_is_branch;
    entry_t w_in_entry;
    entry_t w_head;
    logic   r_br_taken;
    logic   r_ovf_trap;

    assign w_push      = in_valid & in_ready & ~flush;
    assign w_pop       = out_valid & out_ready;
    assign w_is_branch = (br_op_t'(in_br_op) != BR_NONE);
    assign w_taken     = br_resolve(br_op_t'(in_br_op), alu_eq, alu_lt, alu_gt);
    assign w_trap_evt  = w_push & alu_v & in_trap_en;

    // Branches and trapping beats must never reach the register file.
    always_comb begin
        w_in_entry        = '0;
        w_in_entry.result = alu_out;
        w_in_entry.cout   = alu_cout;
        w_in_entry.dest   = in_dest;
        w_in_entry.wr_en  = in_wr_en & ~w_is_branch & ~(alu_v & in_trap_en);
    end

    ex_mem_skid u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (flush),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_entry     (w_in_entry),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .o_head      (w_head)
    );

    // One-cycle taken pulse for the beat accepted on the previous edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_br_taken <= 1'b0;
        else        r_br_taken <= w_push & w_taken;
    end

    // Sticky trap; a new overflow beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_ovf_trap <= 1'b0;
        else if (w_trap_evt) r_ovf_trap <= 1'b1;
        else if (trap_clr)   r_ovf_trap <= 1'b0;
    end

    assign br_taken   = r_br_taken;
    assign ovf_trap   = r_ovf_trap;
    assign out_result = w_head.result;
    assign out_cout   = w_head.cout;
    assign out_dest   = w_head.dest;
    assign out_wr_en  = w_head.wr_en;
    assign fwd_valid  = out_valid & w_head.wr_en;
    assign fwd_dest   = w_head.dest;
    assign fwd_data   = w_head.result;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage with a queue-based reference model.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid, in_ready;
    logic [15:0] alu_out;
    logic        alu_cout, alu_lt, alu_eq, alu_gt, alu_v;
    logic [2:0]  in_dest;
    logic        in_wr_en;
    logic [1:0]  in_br_op;
    logic        in_trap_en, flush, trap_clr;
    logic        out_valid, out_ready;
    logic [15:0] out_result;
    logic        out_cout;
    logic [2:0]  out_dest;
    logic        out_wr_en, br_taken, ovf_trap, fwd_valid;
    logic [2:0]  fwd_dest;
    logic [15:0] fwd_data;

    ex_mem_stage #(.WIDTH(16), .REG_AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .alu_cout(alu_cout), .alu_lt(alu_lt), .alu_eq(alu_eq),
        .alu_gt(alu_gt), .alu_v(alu_v), .in_dest(in_dest), .in_wr_en(in_wr_en),
        .in_br_op(in_br_op), .in_trap_en(in_trap_en), .flush(flush),
        .trap_clr(trap_clr), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_cout(out_cout), .out_dest(out_dest),
        .out_wr_en(out_wr_en), .br_taken(br_taken), .ovf_trap(ovf_trap),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    // Reference model: the buffer is a plain FIFO of at most two beats.
    typedef struct {
        logic [15:0] res;
        logic        cout;
        logic [2:0]  dest;
        logic        we;
    } ment_t;

    ment_t mq[$];
    ment_t m_e;
    logic  m_br   = 1'b0;
    logic  m_trap = 1'b0;
    logic  m_push, m_pop, m_tk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_br   = 1'b0;
            m_trap = 1'b0;
        end else begin
            m_push = in_valid && !flush && (mq.size() < 2);
            m_pop  = !flush && (mq.size() > 0) && out_ready;
            m_tk   = (in_br_op == 2'd1 && alu_eq) || (in_br_op == 2'd2 && alu_lt) ||
                     (in_br_op == 2'd3 && alu_gt);
            m_br   = m_push && m_tk;
            if (flush) mq.delete();
            else begin
                if (m_pop) mq.delete(0);
                if (m_push) begin
                    m_e.res  = alu_out;
                    m_e.cout = alu_cout;
                    m_e.dest = in_dest;
                    m_e.we   = in_wr_en && (in_br_op == 2'd0) && !(alu_v && in_trap_en);
                    mq.push_back(m_e);
                end
            end
            if (m_push && alu_v && in_trap_en) m_trap = 1'b1;
            else if (trap_clr)                 m_trap = 1'b0;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready",  in_ready,  mq.size() < 2);
            chk("out_valid", out_valid, mq.size() > 0);
            chk("br_taken",  br_taken,  m_br);
            chk("ovf_trap",  ovf_trap,  m_trap);
            if (mq.size() > 0) begin
                chk("out_result", out_result, mq[0].res);
                chk("out_cout",   out_cout,   mq[0].cout);
                chk("out_dest",   out_dest,   mq[0].dest);
                chk("out_wr_en",  out_wr_en,  mq[0].we);
                chk("fwd_valid",  fwd_valid,  mq[0].we);
                chk("fwd_dest",   fwd_dest,   mq[0].dest);
                chk("fwd_data",   fwd_data,   mq[0].res);
            end else begin
                chk("fwd_valid_empty", fwd_valid, 0);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        in_valid = 0; alu_out = 0; alu_cout = 0; alu_lt = 0; alu_eq = 0;
        alu_gt = 0; alu_v = 0; in_dest = 0; in_wr_en = 0; in_br_op = 0; in_trap_en = 0;
    endtask

    task automatic beat(input logic [15:0] o, input logic c, input logic lt,
                        input logic eq, input logic gt, input logic v,
                        input logic [2:0] d, input logic we, input logic [1:0] br,
                        input logic te);
        in_valid = 1; alu_out = o; alu_cout = c; alu_lt = lt; alu_eq = eq;
        alu_gt = gt; alu_v = v; in_dest = d; in_wr_en = we; in_br_op = br; in_trap_en = te;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},   in_ready,   1);
        chk({tag, "_out_valid"},  out_valid,  0);
        chk({tag, "_out_result"}, out_result, 0);
        chk({tag, "_out_cout"},   out_cout,   0);
        chk({tag, "_out_dest"},   out_dest,   0);
        chk({tag, "_out_wr_en"},  out_wr_en,  0);
        chk({tag, "_br_taken"},   br_taken,   0);
        chk({tag, "_ovf_trap"},   ovf_trap,   0);
        chk({tag, "_fwd_valid"},  fwd_valid,  0);
        chk({tag, "_fwd_dest"},   fwd_dest,   0);
        chk({tag, "_fwd_data"},   fwd_data,   0);
    endtask

    logic acc;

    initial begin
        idle();
        flush = 0; trap_clr = 0; out_ready = 1;
        #2 rst_n = 0;
        #1 chk_reset_vals("reset");
        tick(); tick();
        rst_n = 1;

        // 200 + 300 captured with one cycle latency
        beat(16'd500, 0, 0, 0, 0, 0, 3'd3, 1, 2'b00, 0);
        tick(); idle();
        chk("add_valid", out_valid, 1);
        chk("add_result", out_result, 500);
        chk("add_dest", out_dest, 3);
        chk("add_fwd_valid", fwd_valid, 1);
        chk("add_fwd_data", fwd_data, 500);
        tick();

        // Stall: 1 and 2 stored, 3 held upstream, then in-order drain
        out_ready = 0;
        beat(16'd1, 0, 0, 0, 0, 0, 3'd1, 1, 2'b00, 0); tick();
        beat(16'd2, 0, 0, 0, 0, 0, 3'd2, 1, 2'b00, 0); tick();
        chk("full_in_ready", in_ready, 0);
        beat(16'd3, 0, 0, 0, 0, 0, 3'd3, 1, 2'b00, 0); tick(); tick();
        chk("stall_head", out_result, 1);
        chk("stall_in_ready", in_ready, 0);
        out_ready = 1;
        tick();
        chk("drain_2", out_result, 2);
        tick();
        chk("drain_3", out_result, 3);
        idle(); tick();
        chk("drain_empty", out_valid, 0);

        // BEQ taken (3 vs 3), BEQ not taken, BLT taken, BGT not taken
        beat(16'd0, 1, 0, 1, 0, 0, 3'd5, 1, 2'b01, 0); tick(); idle();
        chk("beq_pulse", br_taken, 1);
        chk("beq_wr_en", out_wr_en, 0);
        tick();
        chk("beq_pulse_end", br_taken, 0);
        beat(16'hFFFF, 0, 1, 0, 0, 0, 3'd5, 1, 2'b01, 0); tick(); idle();
        chk("beq_nt_pulse", br_taken, 0);
        chk("beq_nt_wr_en", out_wr_en, 0);
        beat(16'hFFFF, 0, 1, 0, 0, 0, 3'd6, 1, 2'b10, 0); tick(); idle();
        chk("blt_pulse", br_taken, 1);
        beat(16'hFFFF, 0, 1, 0, 0, 0, 3'd6, 1, 2'b11, 0); tick(); idle();
        chk("bgt_nt_pulse", br_taken, 0);
        tick();

        // Overflow trap: sticky, suppresses write, cleared by trap_clr
        beat(16'h8000, 0, 0, 0, 0, 1, 3'd2, 1, 2'b00, 1); tick(); idle();
        chk("trap_set", ovf_trap, 1);
        chk("trap_wr_en", out_wr_en, 0);
        beat(16'd7, 0, 0, 0, 0, 0, 3'd4, 1, 2'b00, 0); tick(); idle();
        chk("trap_sticky", ovf_trap, 1);
        chk("after_trap_wr_en", out_wr_en, 1);
        trap_clr = 1; tick(); trap_clr = 0;
        chk("trap_clr", ovf_trap, 0);
        beat(16'h8001, 0, 0, 0, 0, 1, 3'd1, 1, 2'b00, 0); tick(); idle();
        chk("v_no_te_trap", ovf_trap, 0);
        chk("v_no_te_wr_en", out_wr_en, 1);
        beat(16'h7FFF, 0, 0, 0, 0, 1, 3'd1, 1, 2'b00, 1);
        trap_clr = 1; tick(); trap_clr = 0; idle();
        chk("set_wins", ovf_trap, 1);
        trap_clr = 1; tick(); trap_clr = 0;
        chk("clr_again", ovf_trap, 0);

        // Flush from FULL with a taken branch arriving
        out_ready = 0;
        beat(16'd10, 0, 0, 0, 0, 0, 3'd1, 1, 2'b00, 0); tick();
        beat(16'd11, 0, 0, 0, 0, 0, 3'd2, 1, 2'b00, 0); tick();
        beat(16'd0, 0, 0, 1, 0, 0, 3'd3, 1, 2'b01, 0);
        flush = 1; tick(); flush = 0; idle();
        chk("flush_full_valid", out_valid, 0);
        chk("flush_full_br", br_taken, 0);
        chk("flush_full_ready", in_ready, 1);
        // Flush from ONE drops a trapping, taken-branch beat
        beat(16'd20, 0, 0, 0, 0, 0, 3'd1, 1, 2'b00, 0); tick();
        beat(16'h8000, 0, 0, 1, 0, 1, 3'd2, 1, 2'b01, 1);
        flush = 1; tick(); flush = 0; idle();
        chk("flush_one_valid", out_valid, 0);
        chk("flush_one_br", br_taken, 0);
        chk("flush_one_trap", ovf_trap, 0);
        out_ready = 1; tick();

        // Streaming with a fluctuating sink, upstream holds until accepted
        for (int i = 0; i < 12; i++) begin
            beat(16'(100 + i), i[0], 0, 0, 0, 0, 3'(i), 1, 2'b00, 0);
            acc = 0;
            for (int k = 0; k < 10 && !acc; k++) begin
                acc = in_ready;
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            if (!acc) chk("stream_accept", 0, 1);
        end
        idle(); out_ready = 1; tick(); tick(); tick();
        chk("stream_drained", out_valid, 0);

        // Async reset while FULL with the trap set
        out_ready = 0;
        beat(16'd30, 0, 0, 0, 0, 0, 3'd1, 1, 2'b00, 0); tick();
        beat(16'd31, 0, 0, 0, 0, 1, 3'd7, 1, 2'b00, 1); tick(); idle();
        chk("pre_reset_full", in_ready, 0);
        chk("pre_reset_trap", ovf_trap, 1);
        #2 rst_n = 0;
        #1 chk_reset_vals("midreset");
        tick();
        rst_n = 1; out_ready = 1;
        beat(16'd40, 0, 0, 0, 0, 0, 3'd2, 1, 2'b00, 0); tick(); idle();
        chk("post_reset_result", out_result, 40);
        tick(); tick();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline stage of the 16-bit MIPS-style datapath, sitting directly downstream of the ALU. It captures the ALU result and flags (out, Cout, lt, eq, gt, V) together with the instruction's destination and control bits, and resolves conditional branches from the comparison flags. It also turns signed overflow into a sticky trap and buffers up to two entries behind a valid/ready handshake, so a memory-side stall never drops a result. The head entry is exposed to the operand-forwarding path.

## Interface
- WIDTH, 16, datapath width (matches ALU)
- REG_AW, 3, destination register address width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ALU beat valid
- in_ready  out  1  stage can accept (registered)
- alu_out  in  WIDTH  ALU result
- alu_cout, alu_lt, alu_eq, alu_gt, alu_v  in  1 each  ALU flags
- in_dest  in  REG_AW  write-back register
- in_wr_en  in  1  instruction writes a register
- in_br_op  in  2  00 none, 01 BEQ (eq), 10 BLT (lt), 11 BGT (gt)
- in_trap_en  in  1  trap on alu_v
- flush  in  1  discard all buffered and incoming entries
- trap_clr  in  1  clear sticky trap
- out_valid  out  1  head entry valid
- out_ready  in  1  memory stage accepts head
- out_result  out  WIDTH  head result
- out_cout  out  1  head carry
- out_dest  out  REG_AW  head destination
- out_wr_en  out  1  head write enable (after suppression)
- br_taken  out  1  one-cycle pulse: accepted branch taken
- ovf_trap  out  1  sticky overflow trap
- fwd_valid, fwd_dest, fwd_data  out  1/REG_AW/WIDTH  head forwarding copy; fwd_valid = out_valid & out_wr_en

## Operation
- Two-entry in-order buffer; FSM states EMPTY, ONE, FULL.
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready.
- Transitions: EMPTY→ONE on push. ONE→FULL on push & ~pop; ONE→EMPTY on pop & ~push; ONE stays ONE on push & pop. FULL→ONE on pop (no push possible).
- flush (any state) → EMPTY next cycle; the same-cycle incoming beat is dropped, and no br_taken or trap is raised for it. flush has priority over push and pop.
- Branch: taken = (br_op==01 & eq) | (br_op==10 & lt) | (br_op==11 & gt), evaluated at push. A taken or not-taken branch is stored with wr_en forced 0.
- Overflow: alu_v & in_trap_en at push sets ovf_trap; that entry is stored with wr_en forced 0.
- trap_clr clears ovf_trap. If trap_clr and a new trap event occur in the same cycle, set wins.
- Stored result is alu_out unmodified; no width extension and no arithmetic in this stage.

## Timing
- Reset values: in_ready=1, out_valid=0, out_result=0, out_cout=0, out_dest=0, out_wr_en=0, br_taken=0, ovf_trap=0, fwd_*=0, FSM=EMPTY.
- Latency is 1 cycle: out_valid rises the cycle after push.
- in_ready = (next state != FULL), registered. Throughput is one beat per cycle while out_ready stays high.
- The head is held stable while out_valid & ~out_ready.
- br_taken is asserted exactly one cycle after push, for one cycle.
- Reset asserted mid-operation empties the buffer immediately and clears the trap.

## Structure
- Package ex_mem_pkg: br_op_t encoding, state_t (EMPTY/ONE/FULL), entry_t struct (result, cout, dest, wr_en).
- One sub-module, ex_mem_skid: 2-entry buffer plus FSM. The top level holds branch and trap logic and the forwarding outputs.

## Test plan
- ALU 200+300 (alu_out=500, flags 0), in_wr_en=1, in_dest=3, out_ready=1 → next cycle out_valid=1, out_result=500, out_dest=3, fwd_valid=1.
- out_ready=0 while pushing 1, 2, 3 → first two stored, in_ready=0 after the second, third held upstream. Raise out_ready → 1, 2, 3 drain in order.
- in_br_op=01 with alu_eq=1 (3 vs 3) → br_taken pulse one cycle later, out_wr_en=0. Same with alu_eq=0 → no pulse.
- alu_v=1, in_trap_en=1 → ovf_trap=1 stays set across later beats, that entry's out_wr_en=0. trap_clr → 0 next cycle.
- FULL plus flush plus an incoming branch-taken beat → EMPTY, out_valid=0, no br_taken.
- rst_n low while FULL → all outputs at reset values asynchronously, in_ready=1.
